// File: rtl/accel_fir_pkg.sv
// Shared types, width helpers and arithmetic helpers for the multi-channel
// accelerometer FIR filter.
package accel_fir_pkg;

  typedef logic [1:0] fir_state_t;

  localparam fir_state_t ST_IDLE  = 2'd0;
  localparam fir_state_t ST_MAC   = 2'd1;
  localparam fir_state_t ST_ROUND = 2'd2;
  localparam fir_state_t ST_OUT   = 2'd3;

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic int ch_w(input int channels);
    if (channels > 1) begin
      return $clog2(channels);
    end else begin
      return 1;
    end
  endfunction

  // Boxcar average: every tap weighs 1/TAPS in Q1.FRAC_W.
  function automatic int default_coef(input int frac_w, input int taps);
    return (32'sd1 <<< frac_w) / taps;
  endfunction

  // Round half up, arithmetic shift by frac_w, clamp to a signed data_w range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int frac_w,
                                                   input int data_w);
    logic signed [63:0] half_v;
    logic signed [63:0] shifted_v;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] res_v;
    if (frac_w > 0) begin
      half_v = 64'sd1 <<< (frac_w - 1);
    end else begin
      half_v = 64'sd0;
    end
    shifted_v = (acc + half_v) >>> frac_w;
    max_v     = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v     = -(64'sd1 <<< (data_w - 1));
    if (shifted_v > max_v) begin
      res_v = max_v;
    end else if (shifted_v < min_v) begin
      res_v = min_v;
    end else begin
      res_v = shifted_v;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/accel_fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and clamp from the
// accumulator width down to the sample width.
module accel_fir_round_sat
  import accel_fir_pkg::*;
#(
  parameter int ACC_W  = 35,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 15
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] result
);

  logic signed [63:0] acc64_s;
  logic signed [63:0] res64_s;
  logic               unused_hi_s;

  assign acc64_s     = {{(64 - ACC_W){acc[ACC_W-1]}}, acc};
  assign res64_s     = round_sat(acc64_s, FRAC_W, DATA_W);
  // The clamp guarantees the upper bits are pure sign extension.
  assign result      = res64_s[DATA_W-1:0];
  assign unused_hi_s = ^res64_s[63:DATA_W];

endmodule

// File: rtl/accel_fir_mc.sv
// Time-multiplexed multi-channel FIR: one multiply-accumulate per cycle over a
// per-channel sample history with a shared, runtime-loadable coefficient set.
module accel_fir_mc
  import accel_fir_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int FRAC_W   = 15,
  parameter int TAPS     = 8,
  parameter int CHANNELS = 3
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_W-1:0]    in_data,
  input  logic [ch_w(CHANNELS)-1:0]   in_chan,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATA_W-1:0]    out_data,
  output logic [ch_w(CHANNELS)-1:0]   out_chan,
  input  logic                        coef_we,
  input  logic [$clog2(TAPS)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]    coef_data,
  input  logic                        clear
);

  localparam int CH_W = ch_w(CHANNELS);
  localparam int AW   = acc_w(DATA_W, COEF_W, TAPS);
  localparam int TW   = $clog2(TAPS);
  localparam int PW   = DATA_W + COEF_W;
  localparam logic signed [COEF_W-1:0] COEF_RST = COEF_W'(default_coef(FRAC_W, TAPS));

  fir_state_t               state_r;
  logic [CH_W-1:0]          chan_r;
  logic [TW-1:0]            k_r;
  logic signed [AW-1:0]     acc_r;
  logic                     out_valid_r;
  logic signed [DATA_W-1:0] out_data_r;
  logic [CH_W-1:0]          out_chan_r;
  logic signed [DATA_W-1:0] hist_r [CHANNELS][TAPS];
  logic signed [COEF_W-1:0] coef_r [TAPS];

  logic signed [DATA_W-1:0] hsel_s;
  logic signed [COEF_W-1:0] csel_s;
  logic signed [PW-1:0]     hext_s;
  logic signed [PW-1:0]     cext_s;
  logic signed [PW-1:0]     prod_s;
  logic signed [AW-1:0]     prod_ext_s;
  logic signed [DATA_W-1:0] rs_data_s;
  logic                     chan_ok_s;
  logic                     accept_s;

  assign in_ready  = (state_r == ST_IDLE) && !clear;
  assign chan_ok_s = (32'(in_chan) < CHANNELS);
  assign accept_s  = in_valid && in_ready && chan_ok_s;

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_chan  = out_chan_r;

  // Exact full-width product, sign-extended into the accumulator.
  assign hsel_s     = hist_r[chan_r][k_r];
  assign csel_s     = coef_r[k_r];
  assign hext_s     = {{COEF_W{hsel_s[DATA_W-1]}}, hsel_s};
  assign cext_s     = {{DATA_W{csel_s[COEF_W-1]}}, csel_s};
  assign prod_s     = hext_s * cext_s;
  assign prod_ext_s = {{(AW - PW){prod_s[PW-1]}}, prod_s};

  accel_fir_round_sat #(
    .ACC_W  (AW),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_round_sat (
    .acc    (acc_r),
    .result (rs_data_s)
  );

  // Control FSM, accumulator and registered output stage.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r     <= ST_IDLE;
      chan_r      <= '0;
      k_r         <= '0;
      acc_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_chan_r  <= '0;
    end else if (clear) begin
      state_r     <= ST_IDLE;
      k_r         <= '0;
      acc_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            chan_r  <= in_chan;
            acc_r   <= '0;
            k_r     <= '0;
            state_r <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_r <= acc_r + prod_ext_s;
          if (k_r == TW'(TAPS - 1)) begin
            state_r <= ST_ROUND;
          end else begin
            k_r <= k_r + TW'(1);
          end
        end
        ST_ROUND: begin
          out_data_r  <= rs_data_s;
          out_chan_r  <= chan_r;
          out_valid_r <= 1'b1;
          state_r     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-channel sample histories: newest sample enters at tap 0.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int j = 0; j < TAPS; j++) begin
          hist_r[c][j] <= '0;
        end
      end
    end else if (clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int j = 0; j < TAPS; j++) begin
          hist_r[c][j] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (accept_s && (CH_W'(c) == in_chan)) begin
          hist_r[c][0] <= in_data;
          for (int j = 1; j < TAPS; j++) begin
            hist_r[c][j] <= hist_r[c][j-1];
          end
        end
      end
    end
  end

  // Coefficient bank: survives clear, only reset restores the boxcar set.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int j = 0; j < TAPS; j++) begin
        coef_r[j] <= COEF_RST;
      end
    end else if (coef_we && (32'(coef_addr) < TAPS)) begin
      coef_r[coef_addr] <= coef_data;
    end
  end

endmodule

// File: doc/accel_fir_mc.md
# accel_fir_mc

Parametrised, time-multiplexed multi-channel FIR filter for accelerometer samples. Samples from several axes arrive on a valid/ready stream tagged with a channel number. A single sequential multiply-accumulator filters each sample against that channel's private history using a shared, runtime-loadable coefficient set. Rounded, saturated results go out on a valid/ready stream. It sits between the accelerometer SPI sampler and the Nios-visible result registers, and replaces the single-axis software-fed FIR path.

## Interface
Parameters:
- DATA_W, 16, signed sample and result width
- COEF_W, 16, signed coefficient width
- FRAC_W, 15, fractional bits in coefficients (Q1.FRAC_W)
- TAPS, 8, filter length (>=2)
- CHANNELS, 3, number of independent histories (>=1); CH_W = max(1, clog2(CHANNELS))

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous, active-low reset
- in_valid / in_ready  in / out  1 / 1  input handshake
- in_data  in  DATA_W  signed sample
- in_chan  in  CH_W  channel tag
- out_valid / out_ready  out / in  1 / 1  output handshake
- out_data  out  DATA_W  signed filtered result
- out_chan  out  CH_W  channel of out_data
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  tap index
- coef_data  in  COEF_W  signed coefficient
- clear  in  1  synchronous history clear / abort

## Operation
- Accumulator width ACC_W = DATA_W + COEF_W + clog2(TAPS).
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready:
    - in_chan < CHANNELS: shift hist[in_chan] (new sample to [0], oldest discarded), latch chan, acc=0, k=0, go to MAC.
    - in_chan >= CHANNELS: sample consumed and dropped; stay in IDLE, no output, no history change.
  - MAC: each cycle acc += hist[chan][k]*coef[k], k++. After k = TAPS-1, go to ROUND.
  - ROUND: compute out_data = sat((acc + 2^(FRAC_W-1)) >>> FRAC_W) to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Set out_chan=chan and out_valid=1, go to OUT.
  - OUT: out_data and out_chan held stable. When out_ready is high, out_valid falls and the FSM goes to IDLE.
- in_ready = (state==IDLE) && !clear.
- Coefficient writes are accepted in any state and take effect from the next edge. Software writes only while idle; a write mid-MAC is legal but the result mixes old and new coefficients.
- clear, in any state:
  - zeroes all histories;
  - aborts any in-flight computation (the pending out_valid is dropped);
  - returns the FSM to IDLE.
  - Coefficients are untouched.
  - clear has priority over a simultaneous input handshake (that sample is not accepted).

## Timing
- Reset values:
  - state IDLE, out_valid 0, out_data 0, out_chan 0;
  - all histories 0;
  - coef[k] = floor(2^FRAC_W / TAPS), i.e. 4096 by default (boxcar average).
  - in_ready reads 1 after reset because the FSM is in IDLE.
- Reset asserted mid-operation forces the reset values immediately (asynchronously) and drops any pending output.
- Latency: if a sample is accepted at edge 0, out_valid is high starting at edge TAPS+1.
- With out_ready held at 1, the handshake completes at edge TAPS+2 and in_ready is high again after that edge. Throughput is one sample per TAPS+3 cycles.
- Backpressure: out_valid, out_data and out_chan stay constant until the handshake completes, and in_ready stays 0 for that whole time.

## Structure
- Package accel_fir_pkg:
  - state enum;
  - ACC_W / CH_W functions;
  - default-coefficient function;
  - round-and-saturate function.
- Sub-module accel_fir_round_sat: combinational round-half-up, arithmetic shift and clamp from ACC_W to DATA_W. It is unit-testable alone.
- Histories are a CHANNELS×TAPS register array and coefficients a TAPS register array; no RAM inference is required.

## Test plan
- Default coefficients, eight ch0 samples of 800 → outputs 100, 200, …, 800, out_chan=0, each out_valid exactly 9 cycles after acceptance.
- Interleaved ch0=800, ch1=-800, ch2=0 → ch0 100, ch1 -100, ch2 0, with no cross-channel leakage.
- Saturation and rounding:
  - write coef[0]=32767, others 0, then feed 1000 → 1000;
  - write all coefficients 32767, then feed eight samples of 32767 → final output 32767;
  - same coefficients, eight samples of -32768 → final output -32768.
- Backpressure: out_ready held low for 20 cycles with in_valid high → outputs stable and in_ready 0 throughout; on release, exactly one transfer occurs and in_ready is 1 on the following cycle.
- Dropped channel: in_chan=3 with CHANNELS=3 → accepted, no out_valid. A following ch0 sample of 800 on a fresh history → 100.
- Clear and reset:
  - clear pulsed during MAC → no output; next ch0 sample of 800 → 100;
  - reset_reset_n pulsed during OUT → out_valid drops immediately and coefficients return to 4096.
